// File: rtl/mouse_pos_tracker.sv
// rtl/mouse_pos_tracker.sv - PS/2 mouse receiver and clamped cursor position tracker
module mouse_pos_tracker #(
  parameter int H_MAX   = 639,
  parameter int V_MAX   = 479,
  parameter int H_INIT  = 320,
  parameter int V_INIT  = 240,
  parameter int TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [9:0] PosH,
  output logic [9:0] PosV,
  output logic       BtnL,
  output logic       BtnR,
  output logic       pkt_valid,
  output logic       err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TO_SAT  = TW'(TIMEOUT);
  localparam logic signed [11:0] H_LIM = 12'(H_MAX);
  localparam logic signed [11:0] V_LIM = 12'(V_MAX);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

  logic [2:0] clk_sync;
  logic [1:0] dat_sync;
  logic       fall;
  logic       bit_in;

  // Synchronisers idle high so reset never looks like a falling edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync <= 3'b111;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[1:0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
    end
  end

  assign fall   = clk_sync[2] & ~clk_sync[1];
  assign bit_in = dat_sync[1];

  rx_state_t   state;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        par_bit;
  logic [1:0]  idx;
  logic [TW-1:0] to_cnt;
  logic [5:0]  hdr;
  logic [7:0]  dx_byte;
  logic [7:0]  dy_byte;
  logic        upd;
  logic        byte_ok;
  logic        timeout_hit;

  assign byte_ok     = bit_in && (^{shreg, par_bit});
  assign timeout_hit = !fall && (to_cnt == TO_LAST) && ((state != IDLE) || (idx != 2'd0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      idx     <= '0;
      to_cnt  <= '0;
      hdr     <= '0;
      dx_byte <= '0;
      dy_byte <= '0;
      upd     <= 1'b0;
      err     <= 1'b0;
    end else begin
      err <= 1'b0;
      upd <= 1'b0;
      if (fall)
        to_cnt <= '0;
      else if (to_cnt != TO_SAT)
        to_cnt <= to_cnt + 1'b1;

      if (timeout_hit) begin
        state <= IDLE;
        idx   <= '0;
        err   <= 1'b1;
      end else if (fall) begin
        case (state)
          IDLE: begin
            if (!bit_in) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shreg   <= {bit_in, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7)
              state <= PARITY;
          end
          PARITY: begin
            par_bit <= bit_in;
            state   <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (!byte_ok) begin
              err <= 1'b1;
              idx <= '0;
            end else begin
              case (idx)
                2'd0: begin
                  // Bit 3 is always set in a header byte; anything else is misaligned.
                  if (shreg[3]) begin
                    hdr <= {shreg[7:4], shreg[1:0]};
                    idx <= 2'd1;
                  end else begin
                    err <= 1'b1;
                  end
                end
                2'd1: begin
                  dx_byte <= shreg;
                  idx     <= 2'd2;
                end
                default: begin
                  dy_byte <= shreg;
                  idx     <= 2'd0;
                  upd     <= 1'b1;
                end
              endcase
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  logic signed [11:0] dx;
  logic signed [11:0] dy;
  logic signed [11:0] h_new;
  logic signed [11:0] v_new;
  logic [9:0]         h_clamp;
  logic [9:0]         v_clamp;

  // hdr = {Yovf, Xovf, Ysign, Xsign, R, L}
  always_comb begin
    dx    = hdr[4] ? 12'sd0 : $signed({{4{hdr[2]}}, dx_byte});
    dy    = hdr[5] ? 12'sd0 : $signed({{4{hdr[3]}}, dy_byte});
    h_new = $signed({2'b00, PosH}) + dx;
    v_new = $signed({2'b00, PosV}) - dy;
    if (h_new < 0)
      h_clamp = '0;
    else if (h_new > H_LIM)
      h_clamp = H_LIM[9:0];
    else
      h_clamp = h_new[9:0];
    if (v_new < 0)
      v_clamp = '0;
    else if (v_new > V_LIM)
      v_clamp = V_LIM[9:0];
    else
      v_clamp = v_new[9:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PosH      <= 10'(H_INIT);
      PosV      <= 10'(V_INIT);
      BtnL      <= 1'b0;
      BtnR      <= 1'b0;
      pkt_valid <= 1'b0;
    end else begin
      pkt_valid <= 1'b0;
      if (upd) begin
        PosH      <= h_clamp;
        PosV      <= v_clamp;
        BtnL      <= hdr[0];
        BtnR      <= hdr[1];
        pkt_valid <= 1'b1;
      end
    end
  end

endmodule
